// File: rtl/riscv_loader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_loader_pkg: shared constants and FIFO entry type for the   |
// | instruction byte loader.                  Revision: 1.0          |
// +------------------------------------------------------------------+
package riscv_loader_pkg;

  localparam int         INSTR_W         = 32;
  localparam int         BYTES_PER_INSTR = 4;
  localparam logic [1:0] OPC_32BIT       = 2'b11;

  typedef struct packed {
    logic               illegal;
    logic [INSTR_W-1:0] word;
  } loader_entry_t;

  // Anything other than 2'b11 in the low bits is not a 32-bit RV32 encoding.
  function automatic logic is_illegal(input logic [INSTR_W-1:0] word);
    return word[1:0] != OPC_32BIT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/loader_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | loader_fifo: DEPTH-entry FIFO of loader_entry_t with a registered |
// | head output.                              Revision: 1.0          |
// +------------------------------------------------------------------+
module loader_fifo
  import riscv_loader_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  loader_entry_t          push_data,
  input  logic                   pop,
  output loader_entry_t          head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  loader_entry_t r_mem [DEPTH];
  loader_entry_t r_head;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_next;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = pop && !w_empty;
  assign w_push    = push && (!w_full || w_pop);
  assign w_rd_next = r_rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      // Head tracks the oldest entry; with one entry left, a same-edge
      // push becomes the new head directly. Otherwise it holds when empty.
      if (w_pop) begin
        if (r_count > (AW+1)'(1)) begin
          r_head <= r_mem[w_rd_next];
        end else if (w_push) begin
          r_head <= push_data;
        end
      end else if (w_push && w_empty) begin
        r_head <= push_data;
      end
    end
  end

  assign head  = r_head;
  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_byte_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | instr_byte_loader: assembles little-endian bytes into RV32 words |
// | and queues them for the core fetch stage. Revision: 1.0          |
// +------------------------------------------------------------------+
module instr_byte_loader #(
  parameter int DEPTH   = 2,
  parameter int INSTR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             byte_i,
  input  logic                   byte_valid_i,
  output logic                   byte_ready_o,
  input  logic                   sync_i,
  output logic [INSTR_W-1:0]     instr_o,
  output logic                   instr_illegal_o,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);

  import riscv_loader_pkg::*;

  localparam int SHIFT_W = (riscv_loader_pkg::BYTES_PER_INSTR - 1) * 8;

  if (INSTR_W != riscv_loader_pkg::INSTR_W || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("instr_byte_loader: INSTR_W must be 32 and DEPTH a power of two >= 2");
  end

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } byte_state_e;

  byte_state_e          r_state;
  logic [SHIFT_W-1:0]   r_shift;

  loader_entry_t        w_entry;
  loader_entry_t        w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_accept;
  logic [$clog2(DEPTH):0] w_count;

  assign instr_valid_o = !w_empty;
  assign w_pop         = instr_valid_o && instr_ready_i;
  // Only the completing byte can be stalled, and a same-edge pop frees a slot.
  assign byte_ready_o  = (r_state != B3) || !w_full || w_pop;
  assign w_accept      = byte_valid_i && byte_ready_o;
  assign w_push        = w_accept && !sync_i && (r_state == B3);

  assign w_entry.word    = {byte_i, r_shift};
  assign w_entry.illegal = is_illegal({byte_i, r_shift});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= B0;
      r_shift <= '0;
    end else if (sync_i) begin
      r_state <= B0;
      r_shift <= '0;
    end else if (w_accept) begin
      case (r_state)
        B0: begin
          r_shift[7:0] <= byte_i;
          r_state      <= B1;
        end
        B1: begin
          r_shift[15:8] <= byte_i;
          r_state       <= B2;
        end
        B2: begin
          r_shift[23:16] <= byte_i;
          r_state        <= B3;
        end
        default: begin
          r_state <= B0;
        end
      endcase
    end
  end

  loader_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_entry),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign instr_o         = w_head.word;
  assign instr_illegal_o = w_head.illegal;
  assign count_o         = w_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_byte_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_instr_byte_loader: vector table plus randomized scoreboard    |
// | bench for instr_byte_loader.              Revision: 1.0          |
// +------------------------------------------------------------------+
module tb_instr_byte_loader;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    byte_i;
  logic          byte_valid_i;
  logic          byte_ready_o;
  logic          sync_i;
  logic [31:0]   instr_o;
  logic          instr_illegal_o;
  logic          instr_valid_o;
  logic          instr_ready_i;
  logic [CW-1:0] count_o;

  int n_checks = 0;
  int n_fail   = 0;

  instr_byte_loader #(.DEPTH(DEPTH), .INSTR_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .byte_i          (byte_i),
    .byte_valid_i    (byte_valid_i),
    .byte_ready_o    (byte_ready_o),
    .sync_i          (sync_i),
    .instr_o         (instr_o),
    .instr_illegal_o (instr_illegal_o),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .count_o         (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        bv;
    logic [7:0]  b;
    logic        s;
    logic        r;
    int          erdy;   // -1: byte_ready not checked
    logic        ev;
    logic        ci;     // compare instr/illegal after the edge
    logic [31:0] ei;
    logic        eil;
    int          ec;
  } vec_t;

  function automatic vec_t mk(input logic rn, input logic bv, input logic [7:0] b,
                              input logic s, input logic r, input int erdy,
                              input logic ev, input logic ci, input logic [31:0] ei,
                              input logic eil, input int ec);
    vec_t v;
    v.rst_n = rn; v.bv = bv; v.b = b; v.s = s; v.r = r; v.erdy = erdy;
    v.ev = ev; v.ci = ci; v.ei = ei; v.eil = eil; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  vec_t        vec[$];
  logic [7:0]  partial[$];
  logic [32:0] model_q[$];

  initial begin
    int          popped;
    int          cyc;
    logic        bv, r, s, acc, erdy;
    logic [7:0]  b;
    logic [31:0] w;

    rst_n = 1'b0; byte_i = '0; byte_valid_i = 1'b0; sync_i = 1'b0; instr_ready_i = 1'b0;

    // reset, then one word with the core always ready
    vec.push_back(mk(0,0,8'h00,0,0,-1, 0,1,32'h0,0,0));
    vec.push_back(mk(1,1,8'h13,0,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h05,0,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h10,0,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h00,0,1, 1, 1,1,32'h00100513,0,1));
    vec.push_back(mk(1,0,8'h00,0,1, 1, 0,0,32'h0,0,0));
    // reset in the middle of a word
    vec.push_back(mk(1,1,8'hFF,0,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'hEE,0,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(0,0,8'h00,0,0,-1, 0,1,32'h0,0,0));
    vec.push_back(mk(1,1,8'h93,0,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h00,0,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h00,0,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h00,0,1, 1, 1,1,32'h00000093,0,1));
    vec.push_back(mk(1,0,8'h00,0,1, 1, 0,0,32'h0,0,0));
    // non-32-bit encoding
    vec.push_back(mk(1,1,8'h01,0,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h00,0,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h00,0,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h00,0,1, 1, 1,1,32'h00000001,1,1));
    vec.push_back(mk(1,0,8'h00,0,1, 1, 0,0,32'h0,0,0));
    // sync beats the byte offered in the same cycle
    vec.push_back(mk(1,1,8'hAA,0,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'hBB,0,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'hCC,1,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h6F,0,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h00,0,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h00,0,1, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h00,0,1, 1, 1,1,32'h0000006F,0,1));
    vec.push_back(mk(1,0,8'h00,0,1, 1, 0,0,32'h0,0,0));
    // backpressure: three words into a two-entry FIFO
    vec.push_back(mk(1,1,8'h13,0,0, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h00,0,0, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h00,0,0, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h00,0,0, 1, 1,1,32'h00000013,0,1));
    vec.push_back(mk(1,1,8'h93,0,0, 1, 1,1,32'h00000013,0,1));
    vec.push_back(mk(1,1,8'h00,0,0, 1, 1,1,32'h00000013,0,1));
    vec.push_back(mk(1,1,8'hA0,0,0, 1, 1,1,32'h00000013,0,1));
    vec.push_back(mk(1,1,8'h00,0,0, 1, 1,1,32'h00000013,0,2));
    vec.push_back(mk(1,1,8'h23,0,0, 1, 1,1,32'h00000013,0,2));
    vec.push_back(mk(1,1,8'h43,0,0, 1, 1,1,32'h00000013,0,2));
    vec.push_back(mk(1,1,8'h65,0,0, 1, 1,1,32'h00000013,0,2));
    vec.push_back(mk(1,1,8'h87,0,0, 0, 1,1,32'h00000013,0,2));
    vec.push_back(mk(1,1,8'h87,0,0, 0, 1,1,32'h00000013,0,2));
    vec.push_back(mk(1,1,8'h87,0,1, 1, 1,1,32'h00A00093,0,2));
    vec.push_back(mk(1,0,8'h00,0,1, 1, 1,1,32'h87654323,0,1));
    vec.push_back(mk(1,0,8'h00,0,1, 1, 0,0,32'h0,0,0));
    // fill FIFO, start a third word, then reset
    vec.push_back(mk(1,1,8'h13,0,0, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h00,0,0, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h00,0,0, 1, 0,0,32'h0,0,0));
    vec.push_back(mk(1,1,8'h00,0,0, 1, 1,1,32'h00000013,0,1));
    vec.push_back(mk(1,1,8'h13,0,0, 1, 1,1,32'h00000013,0,1));
    vec.push_back(mk(1,1,8'h00,0,0, 1, 1,1,32'h00000013,0,1));
    vec.push_back(mk(1,1,8'h00,0,0, 1, 1,1,32'h00000013,0,1));
    vec.push_back(mk(1,1,8'h00,0,0, 1, 1,1,32'h00000013,0,2));
    vec.push_back(mk(1,1,8'h11,0,0, 1, 1,1,32'h00000013,0,2));
    vec.push_back(mk(1,1,8'h22,0,0, 1, 1,1,32'h00000013,0,2));
    vec.push_back(mk(0,0,8'h00,0,0,-1, 0,1,32'h0,0,0));
    vec.push_back(mk(1,0,8'h00,0,0, 1, 0,0,32'h0,0,0));

    for (int i = 0; i < vec.size(); i++) begin
      rst_n = vec[i].rst_n; byte_valid_i = vec[i].bv; byte_i = vec[i].b;
      sync_i = vec[i].s; instr_ready_i = vec[i].r;
      #1;
      if (vec[i].erdy >= 0) chk($sformatf("byte_ready[%0d]", i), 64'(byte_ready_o), 64'(vec[i].erdy));
      @(posedge clk); #1;
      chk($sformatf("valid[%0d]", i), 64'(instr_valid_o), 64'(vec[i].ev));
      chk($sformatf("count[%0d]", i), 64'(count_o), 64'(vec[i].ec));
      if (vec[i].ci) begin
        chk($sformatf("instr[%0d]", i), 64'(instr_o), 64'(vec[i].ei));
        chk($sformatf("illegal[%0d]", i), 64'(instr_illegal_o), 64'(vec[i].eil));
      end
    end

    // Randomized stream against a queue model; the DUT is freshly reset here.
    popped = 0; bv = 1'b0; b = '0;
    for (cyc = 0; cyc < 60000 && popped < 1000; cyc++) begin
      if (!(bv && !byte_ready_o)) begin
        bv = ($urandom_range(9) < 7);
        b  = 8'($urandom);
      end
      s = ($urandom_range(63) == 0);
      r = ((cyc / 64) % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      rst_n = 1'b1; byte_valid_i = bv; byte_i = b; sync_i = s; instr_ready_i = r;
      #1;
      erdy = (partial.size() != 3) || (model_q.size() < DEPTH) || (model_q.size() > 0 && r);
      chk("rand_byte_ready", 64'(byte_ready_o), 64'(erdy));
      acc = bv && erdy;
      @(posedge clk); #1;
      if (model_q.size() > 0 && r) begin
        void'(model_q.pop_front());
        popped++;
      end
      if (s) begin
        partial.delete();
      end else if (acc) begin
        partial.push_back(b);
        if (partial.size() == 4) begin
          w = {partial[3], partial[2], partial[1], partial[0]};
          model_q.push_back({(w[1:0] != 2'b11), w});
          partial.delete();
        end
      end
      if (acc) bv = 1'b0;
      chk("rand_valid", 64'(instr_valid_o), 64'(model_q.size() > 0));
      chk("rand_count", 64'(count_o), 64'(model_q.size()));
      if (model_q.size() > 0) begin
        chk("rand_instr", 64'(instr_o), 64'(model_q[0][31:0]));
        chk("rand_illegal", 64'(instr_illegal_o), 64'(model_q[0][32]));
      end
    end
    chk("rand_words_done", 64'(popped >= 1000), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
